// File: rtl/eth_rx_frame_classifier.sv
// Registered Ethernet RX frame classifier: header parse, peer SA / length / opcode classes, payload forwarding.
// Define ETH_RX_STATS_EN to add saturating stat_good / stat_bad frame counters.
module eth_rx_frame_classifier #(
  parameter logic [47:0] PEER_MAC  = 48'h0019E075BFFD,
  parameter logic [11:0] IMG_WIDTH = 12'd1024,
  parameter logic [11:0] LEN_CMD   = 12'h034,
  parameter logic [11:0] LEN_ACK   = 12'h018,
  parameter logic [11:0] HDR_ADJ   = 12'd14,
  parameter logic [15:0] OP_A      = 16'h0100,
  parameter logic [15:0] OP_B      = 16'h0300,
  parameter logic [15:0] OP_C      = 16'h0200,
  parameter int unsigned PCNT_W    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic        rx_eof,
  input  logic [31:0] rx_data,
  output logic        hdr_valid,
  output logic        sa_match,
  output logic [1:0]  len_class,
  output logic [1:0]  op_class,
  output logic        pay_valid,
  output logic [31:0] pay_data,
  output logic        pay_last,
  output logic        frame_done,
  output logic        frame_err,
`ifdef ETH_RX_STATS_EN
  output logic        busy,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad
`else
  output logic        busy
`endif
);

  localparam logic [11:0] LEN_DATA = IMG_WIDTH + 12'd16;
  localparam logic [11:0] EXP_MASK = 12'((1 << PCNT_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          hcnt_q, hcnt_d;
  logic [15:0]         sa_hi_q, sa_hi_d;
  logic [31:0]         sa_lo_q, sa_lo_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [11:0]         exp_q, exp_d;

  logic                hdr_valid_q, hdr_valid_d;
  logic                sa_match_q, sa_match_d;
  logic [1:0]          len_class_q, len_class_d;
  logic [1:0]          op_class_q, op_class_d;
  logic                pay_valid_q, pay_valid_d;
  logic [31:0]         pay_data_q, pay_data_d;
  logic                pay_last_q, pay_last_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, frame_err_d;

  logic [11:0]         len_w;
  logic [15:0]         op_w;
  logic [1:0]          len_cls_w;
  logic [1:0]          op_cls_w;
  logic [11:0]         exp_w;
  logic                sa_ok;
  logic [PCNT_W-1:0]   pcnt_nxt;
  logic                pay_hit;

  // Header word 3 decode and payload position, evaluated on the incoming word.
  always_comb begin
    len_w = rx_data[27:16];
    op_w  = rx_data[15:0];

    len_cls_w = 2'd0;
    if (len_w == LEN_CMD)       len_cls_w = 2'd1;
    else if (len_w == LEN_DATA) len_cls_w = 2'd2;
    else if (len_w == LEN_ACK)  len_cls_w = 2'd3;

    op_cls_w = 2'd0;
    if (op_w == OP_A)      op_cls_w = 2'd1;
    else if (op_w == OP_B) op_cls_w = 2'd2;
    else if (op_w == OP_C) op_cls_w = 2'd3;

    exp_w    = ((len_w - HDR_ADJ) >> 2) & EXP_MASK;
    sa_ok    = ({sa_hi_q, sa_lo_q} == PEER_MAC);
    pcnt_nxt = (pcnt_q == '1) ? pcnt_q : pcnt_q + PCNT_W'(1);
    pay_hit  = (12'(pcnt_nxt) == exp_q);
  end

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    sa_hi_d      = sa_hi_q;
    sa_lo_d      = sa_lo_q;
    pcnt_d       = pcnt_q;
    exp_d        = exp_q;
    sa_match_d   = sa_match_q;
    len_class_d  = len_class_q;
    op_class_d   = op_class_q;
    pay_data_d   = pay_data_q;
    hdr_valid_d  = 1'b0;
    pay_valid_d  = 1'b0;
    pay_last_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    if (rx_valid) begin
      if (rx_sof) begin
        // A sof always restarts parsing; only an accepted frame reports the abort.
        if (state_q == S_PAY) frame_err_d = 1'b1;
        if (rx_eof) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HDR;
          hcnt_d  = 2'd1;
        end
      end else begin
        case (state_q)
          S_IDLE: ;
          S_HDR: begin
            if (hcnt_q == 2'd1) sa_hi_d = rx_data[15:0];
            if (hcnt_q == 2'd2) sa_lo_d = rx_data;
            if (hcnt_q != 2'd3) begin
              hcnt_d = hcnt_q + 2'd1;
              if (rx_eof) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
              end
            end else begin
              hdr_valid_d = 1'b1;
              sa_match_d  = sa_ok;
              len_class_d = len_cls_w;
              op_class_d  = op_cls_w;
              if (!sa_ok) begin
                state_d = rx_eof ? S_IDLE : S_DROP;
              end else if (len_cls_w == 2'd0 || exp_w == 12'd0) begin
                frame_err_d = 1'b1;
                state_d     = rx_eof ? S_IDLE : S_DROP;
              end else if (rx_eof) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
              end else begin
                state_d = S_PAY;
                pcnt_d  = '0;
                exp_d   = exp_w;
              end
            end
          end
          S_PAY: begin
            pay_valid_d = 1'b1;
            pay_data_d  = rx_data;
            pcnt_d      = pcnt_nxt;
            if (pay_hit) begin
              pay_last_d   = 1'b1;
              frame_done_d = 1'b1;
              state_d      = rx_eof ? S_IDLE : S_DROP;
            end else if (rx_eof) begin
              frame_err_d = 1'b1;
              state_d     = S_IDLE;
            end
          end
          S_DROP: begin
            if (rx_eof) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hcnt_q       <= '0;
      sa_hi_q      <= '0;
      sa_lo_q      <= '0;
      pcnt_q       <= '0;
      exp_q        <= '0;
      hdr_valid_q  <= 1'b0;
      sa_match_q   <= 1'b0;
      len_class_q  <= '0;
      op_class_q   <= '0;
      pay_valid_q  <= 1'b0;
      pay_data_q   <= '0;
      pay_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      sa_hi_q      <= sa_hi_d;
      sa_lo_q      <= sa_lo_d;
      pcnt_q       <= pcnt_d;
      exp_q        <= exp_d;
      hdr_valid_q  <= hdr_valid_d;
      sa_match_q   <= sa_match_d;
      len_class_q  <= len_class_d;
      op_class_q   <= op_class_d;
      pay_valid_q  <= pay_valid_d;
      pay_data_q   <= pay_data_d;
      pay_last_q   <= pay_last_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign hdr_valid  = hdr_valid_q;
  assign sa_match   = sa_match_q;
  assign len_class  = len_class_q;
  assign op_class   = op_class_q;
  assign pay_valid  = pay_valid_q;
  assign pay_data   = pay_data_q;
  assign pay_last   = pay_last_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);

`ifdef ETH_RX_STATS_EN
  logic [15:0] stat_good_q;
  logic [15:0] stat_bad_q;

  // Counters follow the registered pulses; an SA drop is a hdr_valid with sa_match low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_good_q <= '0;
      stat_bad_q  <= '0;
    end else begin
      if (frame_done_q && stat_good_q != '1)
        stat_good_q <= stat_good_q + 16'd1;
      if ((frame_err_q || (hdr_valid_q && !sa_match_q)) && stat_bad_q != '1)
        stat_bad_q <= stat_bad_q + 16'd1;
    end
  end

  assign stat_good = stat_good_q;
  assign stat_bad  = stat_bad_q;
`endif

endmodule

// File: tb/tb_eth_rx_frame_classifier.sv
// Randomized self-checking bench for eth_rx_frame_classifier with a frame-level reference model.
// Define ETH_RX_STATS_EN to also check the stat counters.
module tb_eth_rx_frame_classifier;

  localparam logic [47:0] PEER  = 48'h0019E075BFFD;
  localparam logic [47:0] OTHER = 48'h001122334455;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_sof = 1'b0;
  logic        rx_eof = 1'b0;
  logic [31:0] rx_data = '0;
  logic        hdr_valid, sa_match, pay_valid, pay_last, frame_done, frame_err, busy;
  logic [1:0]  len_class, op_class;
  logic [31:0] pay_data;
`ifdef ETH_RX_STATS_EN
  logic [15:0] stat_good, stat_bad;
`endif

  eth_rx_frame_classifier dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .rx_data(rx_data), .hdr_valid(hdr_valid), .sa_match(sa_match), .len_class(len_class),
    .op_class(op_class), .pay_valid(pay_valid), .pay_data(pay_data), .pay_last(pay_last),
    .frame_done(frame_done), .frame_err(frame_err),
`ifdef ETH_RX_STATS_EN
    .busy(busy), .stat_good(stat_good), .stat_bad(stat_bad)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Monitor: only ever accumulates; tests work on deltas from snapshots.
  int          mon_hdr = 0, mon_last = 0, mon_done = 0, mon_err = 0, mon_last_pos = 0;
  logic        mon_sa = 1'b0;
  logic [1:0]  mon_lc = '0, mon_oc = '0;
  logic [31:0] mon_pay[$];
  logic [31:0] sent_q[$];

  always @(negedge clk) begin
    if (hdr_valid) begin
      mon_hdr++;
      mon_sa = sa_match;
      mon_lc = len_class;
      mon_oc = op_class;
    end
    if (pay_valid) mon_pay.push_back(pay_data);
    if (pay_last) begin
      mon_last++;
      mon_last_pos = mon_pay.size();
    end
    if (frame_done) mon_done++;
    if (frame_err) mon_err++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  typedef struct {
    int npay;
    int done;
    int err;
  } exp_t;

  function automatic logic [1:0] lcls(input logic [15:0] len);
    case (len[11:0])
      12'h034: return 2'd1;
      12'h410: return 2'd2;
      12'h018: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] ocls(input logic [15:0] op);
    case (op)
      16'h0100: return 2'd1;
      16'h0300: return 2'd2;
      16'h0200: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

  function automatic int ewords(input logic [15:0] len);
    int e;
    e = int'(len[11:0]) - 14;
    if (e < 0) e += 4096;
    return (e / 4) % 1024;
  endfunction

  // n = payload words sent before the frame ends (eof or a following sof).
  function automatic exp_t model(input logic [47:0] sa, input logic [15:0] len, input int n);
    exp_t r;
    int   ew;
    r  = '{npay: 0, done: 0, err: 0};
    ew = ewords(len);
    if (sa != PEER) return r;
    if (lcls(len) == 2'd0 || ew == 0) begin
      r.err = 1;
    end else if (n >= ew) begin
      r.npay = ew;
      r.done = 1;
    end else begin
      r.npay = n;
      r.err  = 1;
    end
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic put(input logic sof, input logic eof, input logic [31:0] d);
    while ($urandom_range(0, 3) == 0) begin
      rx_valid = 1'b0;
      rx_sof   = 1'($urandom);
      rx_eof   = 1'($urandom);
      rx_data  = $urandom;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1; rx_sof = sof; rx_eof = eof; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [47:0] sa, input logic [15:0] len, input logic [15:0] op,
                            input int n, input bit eof_end);
    logic [47:0] da;
    logic [31:0] w;
    int total;
    da    = {16'($urandom), $urandom};
    total = 4 + n;
    for (int i = 0; i < total; i++) begin
      case (i)
        0: w = da[47:16];
        1: w = {da[15:0], sa[47:32]};
        2: w = sa[31:0];
        3: w = {len, op};
        default: begin
          w = $urandom;
          sent_q.push_back(w);
        end
      endcase
      put(i == 0, eof_end && (i == total - 1), w);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int b_pay;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({hdr_valid, sa_match, len_class, op_class, pay_valid, pay_data, pay_last,
         frame_done, frame_err, busy} !== '0)
      $display("FAIL reset_outputs: got hv=%b sa=%b lc=%0d oc=%0d pv=%b pd=%h pl=%b fd=%b fe=%b busy=%b, required all 0",
               hdr_valid, sa_match, len_class, op_class, pay_valid, pay_data, pay_last, frame_done, frame_err, busy);
    else n_pass++;
`ifdef ETH_RX_STATS_EN
    n_checks++;
    if ({stat_good, stat_bad} !== 32'd0)
      $display("FAIL reset_stats: got good=%0d bad=%0d, required 0/0", stat_good, stat_bad);
    else n_pass++;
`endif
    rst_n = 1'b1;
    b_pay = mon_pay.size();
    for (int i = 0; i < 5; i++) put(1'b0, i == 4, $urandom);
    idle(2);
    n_checks++;
    if (busy !== 1'b0 || mon_hdr !== 0 || mon_pay.size() !== b_pay)
      $display("FAIL idle_discard: got busy=%b hdr=%0d pay=%0d, required 0/0/%0d",
               busy, mon_hdr, mon_pay.size(), b_pay);
    else n_pass++;
  endtask

  task automatic test_data_frame();
    int b_hdr, b_pay, b_last, b_done, b_err, bad;
    exp_t e;
`ifdef ETH_RX_STATS_EN
    logic [15:0] b_good;
    b_good = stat_good;
`endif
    b_hdr = mon_hdr; b_pay = mon_pay.size(); b_last = mon_last; b_done = mon_done; b_err = mon_err;
    sent_q.delete();
    send_frame(PEER, 16'h0410, 16'h0300, 256, 1'b1);
    idle(3);
    e = model(PEER, 16'h0410, 256);
    n_checks++;
    if (mon_hdr - b_hdr !== 1 || {mon_sa, mon_lc, mon_oc} !== 5'b1_10_10)
      $display("FAIL data_hdr: got n=%0d sa=%b lc=%0d oc=%0d, required 1/1/2/2",
               mon_hdr - b_hdr, mon_sa, mon_lc, mon_oc);
    else n_pass++;
    n_checks++;
    if (mon_pay.size() - b_pay !== e.npay)
      $display("FAIL data_paycount: got %0d, required %0d", mon_pay.size() - b_pay, e.npay);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < e.npay && b_pay + i < mon_pay.size(); i++)
      if (mon_pay[b_pay + i] !== sent_q[i]) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL data_payload: got %0d wrong words, required 0", bad);
    else n_pass++;
    n_checks++;
    if (mon_last - b_last !== e.done || mon_last_pos - b_pay !== 256)
      $display("FAIL data_last: got count=%0d pos=%0d, required %0d/256",
               mon_last - b_last, mon_last_pos - b_pay, e.done);
    else n_pass++;
    n_checks++;
    if (mon_done - b_done !== e.done || mon_err - b_err !== e.err || busy !== 1'b0)
      $display("FAIL data_end: got done=%0d err=%0d busy=%b, required %0d/%0d/0",
               mon_done - b_done, mon_err - b_err, busy, e.done, e.err);
    else n_pass++;
`ifdef ETH_RX_STATS_EN
    n_checks++;
    if (stat_good - b_good !== 16'd1)
      $display("FAIL stat_good: got delta %0d, required 1", stat_good - b_good);
    else n_pass++;
`endif
  endtask

  task automatic test_ack_pad();
    int b_pay, b_last, b_done, b_err, bad;
    exp_t e;
    b_pay = mon_pay.size(); b_last = mon_last; b_done = mon_done; b_err = mon_err;
    sent_q.delete();
    send_frame(PEER, 16'h0018, 16'h0200, 5, 1'b1);
    idle(3);
    e = model(PEER, 16'h0018, 5);
    n_checks++;
    if ({mon_sa, mon_lc, mon_oc} !== 5'b1_11_11)
      $display("FAIL ack_hdr: got sa=%b lc=%0d oc=%0d, required 1/3/3", mon_sa, mon_lc, mon_oc);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < e.npay && b_pay + i < mon_pay.size(); i++)
      if (mon_pay[b_pay + i] !== sent_q[i]) bad++;
    n_checks++;
    if (mon_pay.size() - b_pay !== e.npay || bad !== 0 || mon_last_pos - b_pay !== 2)
      $display("FAIL ack_pay: got count=%0d wrong=%0d lastpos=%0d, required %0d/0/2",
               mon_pay.size() - b_pay, bad, mon_last_pos - b_pay, e.npay);
    else n_pass++;
    n_checks++;
    if (mon_last - b_last !== 1 || mon_done - b_done !== e.done || mon_err - b_err !== e.err)
      $display("FAIL ack_end: got last=%0d done=%0d err=%0d, required 1/%0d/%0d",
               mon_last - b_last, mon_done - b_done, mon_err - b_err, e.done, e.err);
    else n_pass++;
  endtask

  task automatic test_sa_mismatch();
    int b_hdr, b_pay, b_err, b_done;
`ifdef ETH_RX_STATS_EN
    logic [15:0] b_bad;
    b_bad = stat_bad;
`endif
    b_hdr = mon_hdr; b_pay = mon_pay.size(); b_err = mon_err; b_done = mon_done;
    send_frame(OTHER, 16'h0034, 16'h0100, 9, 1'b1);
    idle(3);
    n_checks++;
    if (mon_hdr - b_hdr !== 1 || {mon_sa, mon_lc, mon_oc} !== 5'b0_01_01)
      $display("FAIL sa_hdr: got n=%0d sa=%b lc=%0d oc=%0d, required 1/0/1/1",
               mon_hdr - b_hdr, mon_sa, mon_lc, mon_oc);
    else n_pass++;
    n_checks++;
    if (mon_pay.size() - b_pay !== 0 || mon_err - b_err !== 0 || mon_done - b_done !== 0)
      $display("FAIL sa_drop: got pay=%0d err=%0d done=%0d, required 0/0/0",
               mon_pay.size() - b_pay, mon_err - b_err, mon_done - b_done);
    else n_pass++;
`ifdef ETH_RX_STATS_EN
    n_checks++;
    if (stat_bad - b_bad !== 16'd1)
      $display("FAIL stat_bad: got delta %0d, required 1", stat_bad - b_bad);
    else n_pass++;
`endif
  endtask

  task automatic test_early_eof();
    int b_pay, b_last, b_err;
    exp_t e;
    b_pay = mon_pay.size(); b_last = mon_last; b_err = mon_err;
    send_frame(PEER, 16'h0410, 16'h0100, 100, 1'b1);
    n_checks++;
    if ({frame_err, busy, pay_last} !== 3'b100)
      $display("FAIL early_eof_pulse: got err=%b busy=%b last=%b, required 1/0/0", frame_err, busy, pay_last);
    else n_pass++;
    idle(3);
    e = model(PEER, 16'h0410, 100);
    n_checks++;
    if (mon_pay.size() - b_pay !== e.npay || mon_last - b_last !== e.done || mon_err - b_err !== e.err)
      $display("FAIL early_eof_totals: got pay=%0d last=%0d err=%0d, required %0d/%0d/%0d",
               mon_pay.size() - b_pay, mon_last - b_last, mon_err - b_err, e.npay, e.done, e.err);
    else n_pass++;
  endtask

  task automatic test_sof_abort();
    int b_hdr, b_pay, b_done, b_err, bad;
    exp_t e1, e2;
    b_hdr = mon_hdr; b_pay = mon_pay.size(); b_done = mon_done; b_err = mon_err;
    sent_q.delete();
    send_frame(PEER, 16'h0410, 16'h0100, 10, 1'b0);
    send_frame(PEER, 16'h0034, 16'h0200, 9, 1'b1);
    idle(3);
    e1 = model(PEER, 16'h0410, 10);
    e2 = model(PEER, 16'h0034, 9);
    n_checks++;
    if (mon_err - b_err !== e1.err + e2.err || mon_done - b_done !== e1.done + e2.done)
      $display("FAIL abort_pulses: got err=%0d done=%0d, required %0d/%0d",
               mon_err - b_err, mon_done - b_done, e1.err + e2.err, e1.done + e2.done);
    else n_pass++;
    n_checks++;
    if (mon_hdr - b_hdr !== 2 || {mon_sa, mon_lc, mon_oc} !== 5'b1_01_11)
      $display("FAIL abort_newhdr: got n=%0d sa=%b lc=%0d oc=%0d, required 2/1/1/3",
               mon_hdr - b_hdr, mon_sa, mon_lc, mon_oc);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < e1.npay + e2.npay && b_pay + i < mon_pay.size(); i++)
      if (mon_pay[b_pay + i] !== sent_q[i]) bad++;
    n_checks++;
    if (mon_pay.size() - b_pay !== e1.npay + e2.npay || bad !== 0 || mon_last_pos - b_pay !== 19)
      $display("FAIL abort_pay: got count=%0d wrong=%0d lastpos=%0d, required %0d/0/19",
               mon_pay.size() - b_pay, bad, mon_last_pos - b_pay, e1.npay + e2.npay);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [47:0] sa;
    logic [15:0] len, op;
    int n, b_hdr, b_pay, b_done, b_err, bad;
    exp_t e;
    for (int f = 0; f < 12; f++) begin
      case ($urandom_range(0, 3))
        0: sa = OTHER;
        1: sa = PEER ^ 48'h1;
        default: sa = PEER;
      endcase
      case ($urandom_range(0, 5))
        0, 1: len = 16'h0034;
        2, 3: len = 16'h0018;
        4: len = (f % 4 == 0) ? 16'h0410 : 16'h0034;
        default: len = {4'($urandom), 12'($urandom)};
      endcase
      case ($urandom_range(0, 3))
        0: op = 16'h0100;
        1: op = 16'h0300;
        2: op = 16'h0200;
        default: op = 16'($urandom);
      endcase
      if (len[11:0] == 12'h410) n = $urandom_range(250, 260);
      else n = $urandom_range(0, 12);
      b_hdr = mon_hdr; b_pay = mon_pay.size(); b_done = mon_done; b_err = mon_err;
      sent_q.delete();
      send_frame(sa, len, op, n, 1'b1);
      idle(2);
      e = model(sa, len, n);
      n_checks++;
      if (mon_hdr - b_hdr !== 1 || mon_sa !== (sa == PEER) || mon_lc !== lcls(len) || mon_oc !== ocls(op))
        $display("FAIL rand_hdr[%0d]: got n=%0d sa=%b lc=%0d oc=%0d, required 1/%b/%0d/%0d",
                 f, mon_hdr - b_hdr, mon_sa, mon_lc, mon_oc, sa == PEER, lcls(len), ocls(op));
      else n_pass++;
      bad = 0;
      for (int i = 0; i < e.npay && b_pay + i < mon_pay.size(); i++)
        if (mon_pay[b_pay + i] !== sent_q[i]) bad++;
      n_checks++;
      if (mon_pay.size() - b_pay !== e.npay || bad !== 0 ||
          mon_done - b_done !== e.done || mon_err - b_err !== e.err)
        $display("FAIL rand_frame[%0d]: got pay=%0d wrong=%0d done=%0d err=%0d, required %0d/0/%0d/%0d",
                 f, mon_pay.size() - b_pay, bad, mon_done - b_done, mon_err - b_err, e.npay, e.done, e.err);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int b_hdr, b_pay, b_err, b_done;
    exp_t e;
    sent_q.delete();
    send_frame(PEER, 16'h0410, 16'h0300, 20, 1'b0);
    rx_valid = 1'b1; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = $urandom;
    @(posedge clk); #2;
    n_checks++;
    if (pay_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL pre_reset_pay: got pv=%b busy=%b, required 1/1", pay_valid, busy);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({hdr_valid, sa_match, len_class, op_class, pay_valid, pay_data, pay_last,
         frame_done, frame_err, busy} !== '0)
      $display("FAIL reset_mid_outputs: got pv=%b pd=%h busy=%b sa=%b lc=%0d, required all 0",
               pay_valid, pay_data, busy, sa_match, len_class);
    else n_pass++;
    rx_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    b_hdr = mon_hdr; b_pay = mon_pay.size(); b_err = mon_err; b_done = mon_done;
    for (int i = 0; i < 30; i++) put(1'b0, i == 29, $urandom);
    idle(2);
    n_checks++;
    if (mon_hdr - b_hdr !== 0 || mon_pay.size() - b_pay !== 0 || mon_err - b_err !== 0 || busy !== 1'b0)
      $display("FAIL reset_tail_discard: got hdr=%0d pay=%0d err=%0d busy=%b, required 0/0/0/0",
               mon_hdr - b_hdr, mon_pay.size() - b_pay, mon_err - b_err, busy);
    else n_pass++;
    sent_q.delete();
    b_pay = mon_pay.size();
    send_frame(PEER, 16'h0034, 16'h0300, 9, 1'b1);
    idle(3);
    e = model(PEER, 16'h0034, 9);
    n_checks++;
    if ({mon_sa, mon_lc, mon_oc} !== 5'b1_01_10 || mon_done - b_done !== e.done ||
        mon_pay.size() - b_pay !== e.npay || mon_pay[mon_pay.size() - 1] !== sent_q[e.npay - 1])
      $display("FAIL post_reset_frame: got sa=%b lc=%0d oc=%0d done=%0d pay=%0d, required 1/1/2/%0d/%0d",
               mon_sa, mon_lc, mon_oc, mon_done - b_done, mon_pay.size() - b_pay, e.done, e.npay);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_data_frame();
    test_ack_pad();
    test_sa_mismatch();
    test_early_eof();
    test_sof_abort();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
